// File: rtl/uart_rx_pkg.sv
//==============================================================================
// Package : uart_pkg
// Desc    : Shared state encoding, parity mode constants and parity helper
//           for the parametrised UART receiver.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    typedef logic [1:0] parity_mode_t;

    localparam parity_mode_t PAR_NONE = 2'd0;
    localparam parity_mode_t PAR_EVEN = 2'd1;
    localparam parity_mode_t PAR_ODD  = 2'd2;

    localparam int MAX_DATA_BITS = 9;

    // Expected parity bit for a zero-extended payload; 0 when parity is off.
    function automatic logic parity_calc(input logic [MAX_DATA_BITS-1:0] data,
                                         input parity_mode_t             mode);
        case (mode)
            PAR_EVEN: return ^data;
            PAR_ODD:  return ~(^data);
            default:  return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
//==============================================================================
// Module : uart_rx_fifo
// Desc   : First-word-fall-through FIFO; head word is visible on dout while
//          non-empty, dout reads zero when empty.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign empty = (r_count == '0);
    assign full  = (r_count == c_cnt_w'(DEPTH));

    // A pop frees a slot in the same cycle, so push-while-full succeeds with it.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    assign dout = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_rx_param.sv
//==============================================================================
// Module : uart_rx_param
// Desc   : Parametrised UART receiver with glitch rejection, sticky error
//          flags and a FWFT receive FIFO.
//          Optional: define UART_RX_MAJORITY_EN for 2-of-3 majority sampling.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 2604,
    parameter int PARITY_MODE  = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 RX,
    input  logic                 pop,
    input  logic                 err_clr,
    output logic                 rdy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 frm_err,
    output logic                 par_err,
    output logic                 overrun
);

    localparam int           c_cnt_w    = $clog2(CLKS_PER_BIT);
    localparam int           c_bit_w    = $clog2(DATA_BITS + 1);
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_half = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(DATA_BITS - 1);
    localparam parity_mode_t c_par_mode = parity_mode_t'(PARITY_MODE);

    logic [1:0]               r_sync;
    logic                     w_rx_s;
    rx_state_t                r_state;
    logic [c_cnt_w-1:0]       r_baud;
    logic [c_bit_w-1:0]       r_bit_cnt;
    logic [DATA_BITS-1:0]     r_shift;
    logic                     r_par_bad;
    logic                     w_active;
    logic                     w_cnt_zero;
    logic                     w_strobe;
    logic                     w_bit;
    logic [MAX_DATA_BITS-1:0] w_shift_ext;
    logic                     w_push;
    logic                     w_frm_set;
    logic                     w_par_set;
    logic                     w_ovr_set;
    logic                     w_empty;
    logic                     w_full;

    // Preset to idle-high so leaving reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], RX};
        end
    end

    assign w_rx_s      = r_sync[1];
    assign w_active    = (r_state != IDLE) && (r_state != BREAK);
    assign w_cnt_zero  = (r_baud == '0);
    assign w_shift_ext = MAX_DATA_BITS'(r_shift);

`ifdef UART_RX_MAJORITY_EN
    localparam logic [c_cnt_w-1:0] c_one = c_cnt_w'(1);

    logic r_smp_a;
    logic r_smp_b;
    logic r_strb_d;

    // Decision is taken one cycle after count 0, with the live bit as third vote.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_smp_a  <= 1'b1;
            r_smp_b  <= 1'b1;
            r_strb_d <= 1'b0;
        end else begin
            if (w_active && (r_baud == c_one)) begin
                r_smp_a <= w_rx_s;
            end
            if (w_active && w_cnt_zero) begin
                r_smp_b <= w_rx_s;
            end
            r_strb_d <= w_active && w_cnt_zero;
        end
    end

    assign w_strobe = r_strb_d && w_active;
    assign w_bit    = (r_smp_a & r_smp_b) | (r_smp_a & w_rx_s) | (r_smp_b & w_rx_s);
`else
    assign w_strobe = w_cnt_zero && w_active;
    assign w_bit    = w_rx_s;
`endif

    // Baud counter free-runs through a frame, reloading a full bit period at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baud <= '0;
        end else if (r_state == IDLE) begin
            if (!w_rx_s) begin
                r_baud <= c_half;
            end
        end else if (w_active) begin
            if (w_cnt_zero) begin
                r_baud <= c_full;
            end else begin
                r_baud <= r_baud - c_cnt_w'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par_bad <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_strobe) begin
                        r_state   <= w_bit ? IDLE : DATA;
                        r_bit_cnt <= '0;
                        r_par_bad <= 1'b0;
                    end
                end
                DATA: begin
                    if (w_strobe) begin
                        r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
                        r_bit_cnt <= r_bit_cnt + c_bit_w'(1);
                        if (r_bit_cnt == c_last_bit) begin
                            r_state <= (c_par_mode != PAR_NONE) ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (w_strobe) begin
                        r_par_bad <= (w_bit != parity_calc(w_shift_ext, c_par_mode));
                        r_state   <= STOP;
                    end
                end
                STOP: begin
                    if (w_strobe) begin
                        r_state <= w_bit ? IDLE : BREAK;
                    end
                end
                BREAK: begin
                    if (w_rx_s) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_push    = (r_state == STOP) && w_strobe && w_bit && !r_par_bad;
    assign w_frm_set = (r_state == STOP) && w_strobe && !w_bit;
    assign w_par_set = (r_state == STOP) && w_strobe && w_bit && r_par_bad;
    assign w_ovr_set = w_push && w_full && !pop;

    // A new error event outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_err <= 1'b0;
            par_err <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (w_frm_set) begin
                frm_err <= 1'b1;
            end else if (err_clr) begin
                frm_err <= 1'b0;
            end
            if (w_par_set) begin
                par_err <= 1'b1;
            end else if (err_clr) begin
                par_err <= 1'b0;
            end
            if (w_ovr_set) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (pop),
        .din   (r_shift),
        .dout  (rx_data),
        .empty (w_empty),
        .full  (w_full)
    );

    assign rdy = ~w_empty;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_param.sv
//==============================================================================
// Module : tb_uart_rx_param
// Desc   : Directed bench for uart_rx_param across four parameter sets
//          (8N, 8 odd parity, 5N, 9N) at 16 clocks per bit.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_uart_rx_param;

    localparam int CPB = 16;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_line  [4];
    logic       pop_line [4];
    logic       clr_line [4];
    logic       rdy [4];
    logic       frm [4];
    logic       par [4];
    logic       ovr [4];
    logic [7:0] dat_a;
    logic [7:0] dat_b;
    logic [4:0] dat_c;
    logic [8:0] dat_d;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    uart_rx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(0), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .rst_n(rst_n), .RX(rx_line[0]), .pop(pop_line[0]), .err_clr(clr_line[0]),
        .rdy(rdy[0]), .rx_data(dat_a), .frm_err(frm[0]), .par_err(par[0]), .overrun(ovr[0]));
    uart_rx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(2), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .rst_n(rst_n), .RX(rx_line[1]), .pop(pop_line[1]), .err_clr(clr_line[1]),
        .rdy(rdy[1]), .rx_data(dat_b), .frm_err(frm[1]), .par_err(par[1]), .overrun(ovr[1]));
    uart_rx_param #(.DATA_BITS(5), .CLKS_PER_BIT(CPB), .PARITY_MODE(0), .FIFO_DEPTH(4)) u_c (
        .clk(clk), .rst_n(rst_n), .RX(rx_line[2]), .pop(pop_line[2]), .err_clr(clr_line[2]),
        .rdy(rdy[2]), .rx_data(dat_c), .frm_err(frm[2]), .par_err(par[2]), .overrun(ovr[2]));
    uart_rx_param #(.DATA_BITS(9), .CLKS_PER_BIT(CPB), .PARITY_MODE(0), .FIFO_DEPTH(4)) u_d (
        .clk(clk), .rst_n(rst_n), .RX(rx_line[3]), .pop(pop_line[3]), .err_clr(clr_line[3]),
        .rdy(rdy[3]), .rx_data(dat_d), .frm_err(frm[3]), .par_err(par[3]), .overrun(ovr[3]));

    // Frame: start, data LSB first, optional parity, stop_low low bits, one high stop.
    task automatic send(input int idx, input logic [8:0] d, input int nbits, input int par_bit,
                        input int stop_low, input int pop_at, input int abort_at);
        int np;
        int total;
        np    = (par_bit >= 0) ? 1 : 0;
        total = (2 + nbits + np + stop_low) * CPB;
        for (int k = 0; k < total; k++) begin
            int   b;
            logic v;
            if (k == abort_at) break;
            b = k / CPB;
            if (b == 0)                          v = 1'b0;
            else if (b <= nbits)                 v = d[b-1];
            else if (b <= nbits + np)            v = par_bit[0];
            else if (b <= nbits + np + stop_low) v = 1'b0;
            else                                 v = 1'b1;
            rx_line[idx]  = v;
            pop_line[idx] = (k == pop_at);
            @(negedge clk);
        end
        rx_line[idx]  = 1'b1;
        pop_line[idx] = 1'b0;
    endtask

    task automatic do_pop(input int idx);
        pop_line[idx] = 1'b1;
        @(negedge clk);
        pop_line[idx] = 1'b0;
    endtask

    task automatic do_clr(input int idx);
        clr_line[idx] = 1'b1;
        @(negedge clk);
        clr_line[idx] = 1'b0;
    endtask

    task automatic test_reset;
        vectors++;
        if ({rdy[0], frm[0], par[0], ovr[0]} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 0000", {rdy[0], frm[0], par[0], ovr[0]});
        end
        vectors++;
        if (dat_a !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_data: got %h want 00", dat_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic;
        logic [7:0] d;
        d = 8'hA5;
        for (int k = 0; k < 176; k++) begin
            int b;
            if (k == 150) begin
                vectors++;
                if (rdy[0] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL basic_early_rdy: got %b want 0", rdy[0]);
                end
            end
            if (k == 163) begin
                vectors++;
                if (rdy[0] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL basic_rdy_163: got %b want 1", rdy[0]);
                end
                vectors++;
                if (dat_a !== 8'hA5) begin
                    miscompares++;
                    $display("FAIL basic_data: got %h want a5", dat_a);
                end
            end
            b = k / CPB;
            rx_line[0] = (b == 0) ? 1'b0 : (b <= 8) ? d[b-1] : 1'b1;
            @(negedge clk);
        end
        do_pop(0);
        vectors++;
        if ({rdy[0], dat_a} !== 9'h000) begin
            miscompares++;
            $display("FAIL basic_after_pop: got rdy=%b data=%h want 0/00", rdy[0], dat_a);
        end
    endtask

    task automatic test_glitch;
        rx_line[0] = 1'b0;
        repeat (4) @(negedge clk);
        rx_line[0] = 1'b1;
        repeat (40) @(negedge clk);
        vectors++;
        if ({rdy[0], frm[0]} !== 2'b00) begin
            miscompares++;
            $display("FAIL glitch_nopush: got rdy/frm=%b want 00", {rdy[0], frm[0]});
        end
        send(0, 9'h03C, 8, -1, 0, -1, -1);
        vectors++;
        if ({rdy[0], dat_a} !== {1'b1, 8'h3C}) begin
            miscompares++;
            $display("FAIL glitch_next: got rdy=%b data=%h want 1/3c", rdy[0], dat_a);
        end
        do_pop(0);
    endtask

    task automatic test_parity;
        send(1, 9'h00F, 8, 0, 0, -1, -1);
        vectors++;
        if ({par[1], rdy[1]} !== 2'b10) begin
            miscompares++;
            $display("FAIL parity_bad: got par/rdy=%b want 10", {par[1], rdy[1]});
        end
        do_clr(1);
        vectors++;
        if (par[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL parity_clr: got %b want 0", par[1]);
        end
        send(1, 9'h00F, 8, 1, 0, -1, -1);
        vectors++;
        if ({rdy[1], par[1], dat_b} !== {2'b10, 8'h0F}) begin
            miscompares++;
            $display("FAIL parity_good: got rdy=%b par=%b data=%h want 1/0/0f", rdy[1], par[1], dat_b);
        end
        do_pop(1);
    endtask

    task automatic test_framing;
        send(0, 9'h055, 8, -1, 3, -1, -1);
        vectors++;
        if ({frm[0], rdy[0]} !== 2'b10) begin
            miscompares++;
            $display("FAIL frame_err: got frm/rdy=%b want 10", {frm[0], rdy[0]});
        end
        send(0, 9'h081, 8, -1, 0, -1, -1);
        vectors++;
        if ({rdy[0], dat_a} !== {1'b1, 8'h81}) begin
            miscompares++;
            $display("FAIL frame_next: got rdy=%b data=%h want 1/81", rdy[0], dat_a);
        end
        do_pop(0);
        vectors++;
        if (rdy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_single_word: got rdy=%b want 0", rdy[0]);
        end
        do_clr(0);
        vectors++;
        if (frm[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_clr: got %b want 0", frm[0]);
        end
    endtask

    task automatic test_overrun;
        for (int i = 1; i <= 5; i++) send(0, 9'(i), 8, -1, 0, -1, -1);
        vectors++;
        if ({ovr[0], rdy[0]} !== 2'b11) begin
            miscompares++;
            $display("FAIL ovr_set: got ovr/rdy=%b want 11", {ovr[0], rdy[0]});
        end
        for (int i = 1; i <= 4; i++) begin
            vectors++;
            if (dat_a !== 8'(i)) begin
                miscompares++;
                $display("FAIL ovr_drain%0d: got %h want %h", i, dat_a, 8'(i));
            end
            do_pop(0);
        end
        vectors++;
        if (rdy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL ovr_empty: got rdy=%b want 0", rdy[0]);
        end
        do_clr(0);
        vectors++;
        if (ovr[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL ovr_clr: got %b want 0", ovr[0]);
        end
    endtask

    task automatic test_overrun_pop;
        for (int i = 1; i <= 4; i++) send(0, 9'(i), 8, -1, 0, -1, -1);
        send(0, 9'h005, 8, -1, 0, 154 + LAT, -1);
        vectors++;
        if ({ovr[0], rdy[0], dat_a} !== {2'b01, 8'h02}) begin
            miscompares++;
            $display("FAIL ovr_pop_same: got ovr=%b rdy=%b data=%h want 0/1/02", ovr[0], rdy[0], dat_a);
        end
        for (int i = 2; i <= 5; i++) begin
            vectors++;
            if (dat_a !== 8'(i)) begin
                miscompares++;
                $display("FAIL ovr_pop_drain%0d: got %h want %h", i, dat_a, 8'(i));
            end
            do_pop(0);
        end
    endtask

    task automatic test_width5;
        send(2, 9'h015, 5, -1, 0, -1, -1);
        vectors++;
        if ({rdy[2], dat_c} !== {1'b1, 5'h15}) begin
            miscompares++;
            $display("FAIL w5_data: got rdy=%b data=%h want 1/15", rdy[2], dat_c);
        end
        do_pop(2);
    endtask

    task automatic test_width9_reset;
        send(3, 9'h1AB, 9, -1, 0, -1, -1);
        vectors++;
        if ({rdy[3], dat_d} !== {1'b1, 9'h1AB}) begin
            miscompares++;
            $display("FAIL w9_data: got rdy=%b data=%h want 1/1ab", rdy[3], dat_d);
        end
        send(0, 9'h077, 8, -1, 0, -1, -1);
        send(3, 9'h0F0, 9, -1, 0, -1, 70);
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({rdy[3], frm[3], par[3], ovr[3], dat_d} !== 13'h0) begin
            miscompares++;
            $display("FAIL rst_mid_d: got rdy=%b data=%h flags=%b%b%b want all 0", rdy[3], dat_d, frm[3], par[3], ovr[3]);
        end
        vectors++;
        if ({rdy[0], dat_a} !== 9'h0) begin
            miscompares++;
            $display("FAIL rst_mid_a: got rdy=%b data=%h want 0/00", rdy[0], dat_a);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        send(3, 9'h0C3, 9, -1, 0, -1, -1);
        vectors++;
        if ({rdy[3], frm[3], dat_d} !== {2'b10, 9'h0C3}) begin
            miscompares++;
            $display("FAIL rst_next: got rdy=%b frm=%b data=%h want 1/0/0c3", rdy[3], frm[3], dat_d);
        end
        do_pop(3);
        vectors++;
        if (rdy[3] !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_next_pop: got rdy=%b want 0", rdy[3]);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            rx_line[i]  = 1'b1;
            pop_line[i] = 1'b0;
            clr_line[i] = 1'b0;
        end
        @(negedge clk);
        test_reset();
        test_basic();
        test_glitch();
        test_parity();
        test_framing();
        test_overrun();
        test_overrun_pop();
        test_width5();
        test_width9_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
